// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / RV32M execute unit: opcode constants,
// FSM state type and the default datapath width.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  localparam logic [4:0] MD_MUL    = 5'b10000;
  localparam logic [4:0] MD_MULH   = 5'b10001;
  localparam logic [4:0] MD_MULHSU = 5'b10010;
  localparam logic [4:0] MD_MULHU  = 5'b10011;
  localparam logic [4:0] MD_DIV    = 5'b10100;
  localparam logic [4:0] MD_DIVU   = 5'b10101;
  localparam logic [4:0] MD_REM    = 5'b10110;
  localparam logic [4:0] MD_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_md_unit_if.sv
// Operand/result handshake bundle between the EX stage and alu_md_unit.
interface alu_md_unit_if
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero_flag;
  logic            busy;

  modport master (
    output in_valid, op, in1, in2, out_ready,
    input  in_ready, out_valid, result, zero_flag, busy
  );

  modport slave (
    input  in_valid, op, in1, in2, out_ready,
    output in_ready, out_valid, result, zero_flag, busy
  );
endinterface

// File: rtl/alu_core.sv
// Combinational base-op datapath of the execute unit (logic, add/sub,
// compares, shifts); unknown codes produce zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] result
);
  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  assign shamt = in2[SH_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_AND:  result = in1 & in2;
      ALU_OR:   result = in1 | in2;
      ALU_ADD:  result = in1 + in2;
      ALU_SUB:  result = in1 - in2;
      ALU_XOR:  result = in1 ^ in2;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (in1 < in2)};
      ALU_SLL:  result = in1 << shamt;
      ALU_SRL:  result = in1 >> shamt;
      ALU_SRA:  result = XLEN'($signed(in1) >>> shamt);
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/alu_md_unit.sv
// Multi-cycle EX unit: base ALU ops in one cycle, RV32M mul/div radix-2
// iterative. Define ALU_MD_FAST_MUL_EN for a single-cycle multiplier.
module alu_md_unit
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  alu_md_unit_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t state_q, state_d;

  logic [XLEN-1:0]   res_q;
  logic              zf_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   a_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              q_neg_q, r_neg_q, sel_q;

  // Operand decode
  logic            is_mul, is_div, is_rem, a_sgn, b_sgn;
  logic            a_neg, b_neg, div_zero, div_ovf, div_special, mul_iter, mul_hi;
  logic [XLEN-1:0] abs_a, abs_b, core_res, imm_res;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    is_rem = 1'b0;
    a_sgn  = 1'b0;
    b_sgn  = 1'b0;
    case (bus.op)
      MD_MUL, MD_MULH: begin is_mul = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
      MD_MULHSU:       begin is_mul = 1'b1; a_sgn = 1'b1; end
      MD_MULHU:        is_mul = 1'b1;
      MD_DIV:          begin is_div = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
      MD_DIVU:         is_div = 1'b1;
      MD_REM:          begin is_div = 1'b1; is_rem = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
      MD_REMU:         begin is_div = 1'b1; is_rem = 1'b1; end
      default: ;
    endcase
  end

  assign a_neg       = a_sgn & bus.in1[XLEN-1];
  assign b_neg       = b_sgn & bus.in2[XLEN-1];
  assign abs_a       = a_neg ? -bus.in1 : bus.in1;
  assign abs_b       = b_neg ? -bus.in2 : bus.in2;
  assign mul_hi      = (bus.op[1:0] != 2'b00);
  assign div_zero    = (bus.in2 == '0);
  assign div_ovf     = a_sgn & b_sgn & (bus.in1 == MIN_NEG) & (bus.in2 == '1);
  assign div_special = is_div & (div_zero | div_ovf);

  alu_core #(.XLEN(XLEN)) u_core (
    .in1    (bus.in1),
    .in2    (bus.in2),
    .op     (bus.op[3:0]),
    .result (core_res)
  );

`ifdef ALU_MD_FAST_MUL_EN
  logic signed [XLEN:0]   fa, fb;
  logic [2*XLEN-1:0]      fprod;
  logic [XLEN-1:0]        fast_res;
  assign fa       = {a_sgn & bus.in1[XLEN-1], bus.in1};
  assign fb       = {b_sgn & bus.in2[XLEN-1], bus.in2};
  assign fprod    = (2*XLEN)'(fa * fb);
  assign fast_res = mul_hi ? fprod[2*XLEN-1:XLEN] : fprod[XLEN-1:0];
  assign mul_iter = 1'b0;
`else
  assign mul_iter = is_mul;
`endif

  // Results that complete in the accepting cycle
  always_comb begin
    imm_res = '0;
    if (!bus.op[4])
      imm_res = core_res;
    else if (div_special)
      imm_res = div_zero ? (is_rem ? bus.in1 : '1) : (is_rem ? '0 : bus.in1);
`ifdef ALU_MD_FAST_MUL_EN
    else if (is_mul)
      imm_res = fast_res;
`endif
  end

  // Multiply step: multiplier sits in the low half of acc_q and shifts out
  // as the partial product shifts in from the top.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, mul_prod;
  logic [XLEN-1:0]   mul_res;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_prod = q_neg_q ? -mul_next : mul_next;
  assign mul_res  = sel_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];

  // Restoring divide step: remainder in the high half, dividend bits shift
  // out of the low half while quotient bits shift in.
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff, div_quo, div_rem, div_res;
  logic [2*XLEN-1:0] div_next;
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, a_q});
  assign div_diff  = XLEN'(div_shift - {1'b0, a_q});
  assign div_next  = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                            : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  assign div_quo   = q_neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
  assign div_rem   = r_neg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
  assign div_res   = sel_q ? div_rem : div_quo;

  logic last_step;
  assign last_step = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (bus.in_valid) begin
          if (mul_iter)                  state_d = ST_MUL;
          else if (is_div && !div_special) state_d = ST_DIV;
          else                           state_d = ST_DONE;
        end
      ST_MUL, ST_DIV:
        if (last_step) state_d = ST_DONE;
      ST_DONE:
        if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
    bus.out_valid = (state_q == ST_DONE);
    bus.result    = res_q;
    bus.zero_flag = zf_q;
  end

  // flush freezes the datapath so result keeps its previous value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      zf_q    <= 1'b0;
      acc_q   <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      sel_q   <= 1'b0;
    end else if (!flush) begin
      case (state_q)
        ST_IDLE:
          if (bus.in_valid) begin
            cnt_q   <= CNT_W'(XLEN);
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            if (mul_iter) begin
              a_q   <= abs_a;
              acc_q <= {{XLEN{1'b0}}, abs_b};
              sel_q <= mul_hi;
            end else if (is_div && !div_special) begin
              a_q   <= abs_b;
              acc_q <= {{XLEN{1'b0}}, abs_a};
              sel_q <= is_rem;
            end else begin
              res_q <= imm_res;
              zf_q  <= (imm_res == '0);
            end
          end
        ST_MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q - 1'b1;
          if (last_step) begin
            res_q <= mul_res;
            zf_q  <= (mul_res == '0);
          end
        end
        ST_DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q - 1'b1;
          if (last_step) begin
            res_q <= div_res;
            zf_q  <= (div_res == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_md_unit.sv
// Randomized self-checking bench for alu_md_unit (XLEN=32) against an
// arithmetic reference model.
module tb_alu_md_unit;
  localparam int XLEN = 32;

  logic clk, rst_n, flush;
  int total = 0;
  int bad   = 0;

  alu_md_unit_if #(.XLEN(XLEN)) bus ();

  alu_md_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pa, pb, prod;
    int sh, ia, ib;
    logic ovf;
    sh   = int'(b[4:0]);
    ia   = a;
    ib   = b;
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    pa   = {{32{a[31] && (op == 5'b10000 || op == 5'b10001 || op == 5'b10010)}}, a};
    pb   = {{32{b[31] && (op == 5'b10000 || op == 5'b10001)}}, b};
    prod = pa * pb;
    case (op)
      5'b00000: return a & b;
      5'b00001: return a | b;
      5'b00010: return a + b;
      5'b00100: return a - b;
      5'b00111: return a ^ b;
      5'b01000: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'b01001: return (a < b) ? 32'd1 : 32'd0;
      5'b00011: return a << sh;
      5'b00101: return a >> sh;
      5'b01010: return 32'($signed(a) >>> sh);
      5'b10000: return prod[31:0];
      5'b10001, 5'b10010, 5'b10011: return prod[63:32];
      5'b10100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      5'b10101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'b10110: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      5'b10111: return (b == 0) ? a : a % b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[4:3] != 2'b10) return 1;
    if (op[2]) begin
      if (b == 0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
    end
`ifdef ALU_MD_FAST_MUL_EN
    return 1;
`else
    return XLEN + 1;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // Issues one op, counts cycles from the accepting edge to out_valid,
  // then pops the result.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic zf, output int lat);
    @(negedge clk);
    bus.op = op; bus.in1 = a; bus.in2 = b;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    zf  = bus.zero_flag;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=%h", bus.result, 32'd0); end
    total++; if (bus.zero_flag !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", bus.zero_flag); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
  endtask

  task automatic check_op(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res, exp;
    logic zf;
    int lat, elat;
    exp  = model(op, a, b);
    elat = exp_lat(op, a, b);
    do_op(op, a, b, res, zf, lat);
    total++;
    if (res !== exp) begin bad++; $display("FAIL %s_result op=%b a=%h b=%h got=%h want=%h", name, op, a, b, res, exp); end
    total++;
    if (zf !== (exp == 0)) begin bad++; $display("FAIL %s_zero op=%b a=%h b=%h got=%b want=%b", name, op, a, b, zf, exp == 0); end
    total++;
    if (lat != elat) begin bad++; $display("FAIL %s_latency op=%b a=%h b=%h got=%0d want=%0d", name, op, a, b, lat, elat); end
  endtask

  task automatic test_base();
    logic [4:0] op;
    check_op("add", 5'b00010, 32'd5, 32'd7);
    check_op("sub", 5'b00100, 32'd9, 32'd9);
    for (int i = 0; i < 40; i++) begin
      op = {1'b0, 4'($urandom_range(0, 15))};
      check_op("base", op, pick(), pick());
    end
    for (int i = 0; i < 4; i++) begin
      op = {2'b11, 3'($urandom_range(0, 7))};
      check_op("undef", op, $urandom(), $urandom());
    end
  endtask

  task automatic test_mul();
    check_op("mulh", 5'b10001, 32'h8000_0000, 32'h8000_0000);
    check_op("mul", 5'b10000, 32'hFFFF_FFFD, 32'd7);
    for (int i = 0; i < 24; i++)
      check_op("mul_rand", {3'b100, 2'($urandom_range(0, 3))}, pick(), pick());
  endtask

  task automatic test_div();
    check_op("div", 5'b10100, 32'hFFFF_FFF9, 32'd2);
    check_op("rem", 5'b10110, 32'hFFFF_FFF9, 32'd2);
    check_op("divu_zero", 5'b10101, 32'hFFFF_FFFF, 32'd0);
    check_op("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("rem_zero", 5'b10110, 32'h1234_5678, 32'd0);
    for (int i = 0; i < 30; i++)
      check_op("div_rand", {3'b101, 2'($urandom_range(0, 3))}, pick(), pick());
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    bus.op = 5'b10000; bus.in1 = 32'd6; bus.in2 = 32'd7;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.op = 5'b00010; bus.in1 = 32'd100; bus.in2 = 32'd1;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_done_timeout got=%b want=1", bus.out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.result !== 32'd42) begin bad++; $display("FAIL bp_hold_result cycle=%0d got=%h want=%h", i, bus.result, 32'd42); end
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold_state cycle=%0d got in_ready=%b out_valid=%b want 0/1", i, bus.in_ready, bus.out_valid);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_second_accept got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    int seen;
    prev = bus.result;
    @(negedge clk);
    bus.op = 5'b10101; bus.in1 = 32'd1000; bus.in2 = 32'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL flush_busy_before got=%b want=1", bus.busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL flush_idle got in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy);
    end
    total++;
    if (bus.result !== prev) begin bad++; $display("FAIL flush_result_kept got=%h want=%h", bus.result, prev); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL flush_no_valid got=%0d want=0", seen); end
    // flush beats a simultaneous accept
    @(negedge clk);
    bus.op = 5'b00010; bus.in1 = 32'd3; bus.in2 = 32'd4; bus.in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_vs_accept got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    check_op("after_flush", 5'b00010, 32'd1, 32'd1);
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    bus.op = 5'b10001; bus.in1 = 32'h1234_5678; bus.in2 = 32'h9ABC_DEF0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_busy_before got=%b want=1", bus.busy); end
    rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_release got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    total++;
    if (bus.result !== 32'd0) begin bad++; $display("FAIL rst_release_result got=%h want=0", bus.result); end
    check_op("after_reset", 5'b10000, 32'hFFFF_FFFD, 32'h0000_0007);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = '0; bus.in1 = '0; bus.in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_base();
    test_mul();
    test_div();
    test_backpressure();
    test_flush();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
